// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, variable-latency imem req/ack port, one-entry skid
// buffer and the IF/ID register with stall / flush / redirect handling.
module fetch_stage #(
    parameter int unsigned      WIDTH    = 22,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned      PC_STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_d,
    input  logic             flush_d,
    input  logic             pc_src_w,
    input  logic [WIDTH-1:0] branch_target_in,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instruction_decode_out,
    output logic [WIDTH-1:0] pc_plus_8_out,
    output logic             valid_decode_out,
    output logic             fetch_busy,
    output logic [1:0]       state_dbg_o
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HOLD    = 2'd1,
        S_DISCARD = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] STEP_1 = WIDTH'(PC_STEP);
    localparam logic [WIDTH-1:0] STEP_2 = WIDTH'(2 * PC_STEP);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] disc_addr_q, disc_addr_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc8_q, pc8_d;
    logic             valid_q, valid_d;
    logic             bubble;
    logic             ack_v;

    // imem handshake: imem_req stays high with imem_addr stable until the cycle
    // imem_ack is seen; that cycle completes the request. imem_ack while imem_req
    // is low carries no meaning and is ignored.
    assign imem_req   = !rst && (state_q != S_HOLD);
    assign imem_addr  = (state_q == S_DISCARD) ? disc_addr_q : pc_q;
    assign ack_v      = imem_req && imem_ack;
    assign fetch_busy = imem_req && !imem_ack;

    assign instruction_decode_out = instr_q;
    assign pc_plus_8_out          = pc8_q;
    assign valid_decode_out       = valid_q;
    assign state_dbg_o            = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            disc_addr_q <= '0;
            skid_q      <= '0;
            instr_q     <= '0;
            pc8_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            disc_addr_q <= disc_addr_d;
            skid_q      <= skid_d;
            instr_q     <= instr_d;
            pc8_q       <= pc8_d;
            valid_q     <= valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        disc_addr_d = disc_addr_q;
        skid_d      = skid_q;
        instr_d     = instr_q;
        pc8_d       = pc8_q;
        valid_d     = valid_q;
        bubble      = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (pc_src_w) begin
                    pc_d   = branch_target_in;
                    bubble = 1'b1;
                    // The in-flight request must still be completed at its old address.
                    if (!ack_v) begin
                        state_d     = S_DISCARD;
                        disc_addr_d = pc_q;
                    end
                end else if (flush_d) begin
                    bubble = 1'b1;
                end else if (stall_d) begin
                    if (ack_v) begin
                        skid_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end else if (ack_v) begin
                    instr_d = imem_rdata;
                    pc8_d   = pc_q + STEP_2;
                    valid_d = 1'b1;
                    pc_d    = pc_q + STEP_1;
                end else begin
                    bubble = 1'b1;
                end
            end

            S_HOLD: begin
                if (pc_src_w) begin
                    pc_d    = branch_target_in;
                    bubble  = 1'b1;
                    state_d = S_FETCH;
                end else if (flush_d) begin
                    bubble  = 1'b1;
                    state_d = S_FETCH;
                end else if (!stall_d) begin
                    instr_d = skid_q;
                    pc8_d   = pc_q + STEP_2;
                    valid_d = 1'b1;
                    pc_d    = pc_q + STEP_1;
                    state_d = S_FETCH;
                end
            end

            S_DISCARD: begin
                if (ack_v) begin
                    state_d = S_FETCH;
                end
                if (pc_src_w) begin
                    pc_d   = branch_target_in;
                    bubble = 1'b1;
                end else if (flush_d || !stall_d) begin
                    bubble = 1'b1;
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (bubble) begin
            instr_d = '0;
            pc8_d   = '0;
            valid_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios, then a randomized run compared against
// a behavioural model of the instruction stream.
module tb_fetch_stage;
    localparam int W = 22;
    localparam logic [W-1:0] ALIGN_MASK = 22'h3FFFFC;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stall_d = 1'b0;
    logic         flush_d = 1'b0;
    logic         pc_src_w = 1'b0;
    logic [W-1:0] branch_target_in = '0;
    logic         imem_ack = 1'b0;
    logic [W-1:0] imem_rdata = '0;
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic [W-1:0] instruction_decode_out;
    logic [W-1:0] pc_plus_8_out;
    logic         valid_decode_out;
    logic         fetch_busy;
    logic [1:0]   state_dbg_o;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    fetch_stage #(.WIDTH(W), .RESET_PC(22'h0), .PC_STEP(4)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .stall_d                (stall_d),
        .flush_d                (flush_d),
        .pc_src_w               (pc_src_w),
        .branch_target_in       (branch_target_in),
        .imem_req               (imem_req),
        .imem_addr              (imem_addr),
        .imem_ack               (imem_ack),
        .imem_rdata             (imem_rdata),
        .instruction_decode_out (instruction_decode_out),
        .pc_plus_8_out          (pc_plus_8_out),
        .valid_decode_out       (valid_decode_out),
        .fetch_busy             (fetch_busy),
        .state_dbg_o            (state_dbg_o)
    );

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return W'(a * 37) ^ 22'h2A5A5;
    endfunction

    task automatic set_in(input logic s, input logic f, input logic r, input logic [W-1:0] t,
                          input logic a, input logic [W-1:0] d);
        stall_d = s;
        flush_d = f;
        pc_src_w = r;
        branch_target_in = t;
        imem_ack = a;
        imem_rdata = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, 22'h15555);
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b exp 0", imem_req); end
        checks++; if (fetch_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b exp 0", fetch_busy); end
        checks++; if (instruction_decode_out !== 22'h0) begin failures++; $display("FAIL rst_instr: got %h exp 0", instruction_decode_out); end
        checks++; if (pc_plus_8_out !== 22'h0) begin failures++; $display("FAIL rst_pc8: got %h exp 0", pc_plus_8_out); end
        checks++; if (valid_decode_out !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b exp 0", valid_decode_out); end
        checks++; if (state_dbg_o !== 2'd0) begin failures++; $display("FAIL rst_state: got %0d exp 0", state_dbg_o); end
        @(negedge clk);
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        #1;
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rel_req: got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 22'h0) begin failures++; $display("FAIL rel_addr: got %h exp 0", imem_addr); end
        checks++; if (fetch_busy !== 1'b1) begin failures++; $display("FAIL rel_busy: got %b exp 1", fetch_busy); end
    endtask

    task automatic test_zero_wait();
        logic [W-1:0] e;
        do_reset();
        exp_q.delete();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, mem_word(W'(4 * k)));
            #1;
            checks++; if (imem_addr !== W'(4 * k)) begin failures++; $display("FAIL zw_addr k=%0d: got %h exp %h", k, imem_addr, W'(4 * k)); end
            if (k == 0) begin
                checks++; if (valid_decode_out !== 1'b0) begin failures++; $display("FAIL zw_valid0: got %b exp 0", valid_decode_out); end
            end else begin
                e = exp_q.pop_front();
                checks++; if (instruction_decode_out !== e) begin failures++; $display("FAIL zw_instr k=%0d: got %h exp %h", k, instruction_decode_out, e); end
                checks++; if (pc_plus_8_out !== W'(4 * k + 4)) begin failures++; $display("FAIL zw_pc8 k=%0d: got %h exp %h", k, pc_plus_8_out, W'(4 * k + 4)); end
                checks++; if (valid_decode_out !== 1'b1) begin failures++; $display("FAIL zw_valid k=%0d: got %b exp 1", k, valid_decode_out); end
            end
            exp_q.push_back(mem_word(W'(4 * k)));
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                set_in(1'b0, 1'b0, 1'b0, '0, 1'(c == 2), mem_word(W'(4 * i)));
                #1;
                checks++; if (imem_addr !== W'(4 * i)) begin failures++; $display("FAIL ws_addr i=%0d c=%0d: got %h exp %h", i, c, imem_addr, W'(4 * i)); end
                checks++; if (fetch_busy !== 1'(c != 2)) begin failures++; $display("FAIL ws_busy i=%0d c=%0d: got %b exp %b", i, c, fetch_busy, 1'(c != 2)); end
                if (c == 0 && i > 0) begin
                    checks++; if (instruction_decode_out !== mem_word(W'(4 * (i - 1)))) begin failures++; $display("FAIL ws_instr i=%0d: got %h exp %h", i, instruction_decode_out, mem_word(W'(4 * (i - 1)))); end
                    checks++; if (valid_decode_out !== 1'b1) begin failures++; $display("FAIL ws_valid i=%0d: got %b exp 1", i, valid_decode_out); end
                end else begin
                    checks++; if (instruction_decode_out !== 22'h0) begin failures++; $display("FAIL ws_bub_instr i=%0d c=%0d: got %h exp 0", i, c, instruction_decode_out); end
                    checks++; if (valid_decode_out !== 1'b0) begin failures++; $display("FAIL ws_bub_valid i=%0d c=%0d: got %b exp 0", i, c, valid_decode_out); end
                end
            end
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, mem_word(22'h0));
        @(negedge clk);
        set_in(1'b1, 1'b0, 1'b0, '0, 1'b1, 22'h12345);
        #1;
        checks++; if (imem_addr !== 22'h4) begin failures++; $display("FAIL st_addr: got %h exp 4", imem_addr); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            set_in(1'b1, 1'b0, 1'b0, '0, 1'b1, 22'h3FFFF);
            #1;
            checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL st_req k=%0d: got %b exp 0", k, imem_req); end
            checks++; if (state_dbg_o !== 2'd1) begin failures++; $display("FAIL st_state k=%0d: got %0d exp 1", k, state_dbg_o); end
            checks++; if (instruction_decode_out !== mem_word(22'h0)) begin failures++; $display("FAIL st_held k=%0d: got %h exp %h", k, instruction_decode_out, mem_word(22'h0)); end
            checks++; if (pc_plus_8_out !== 22'h8) begin failures++; $display("FAIL st_held_pc8 k=%0d: got %h exp 8", k, pc_plus_8_out); end
        end
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        #1;
        checks++; if (instruction_decode_out !== mem_word(22'h0)) begin failures++; $display("FAIL st_rel_held: got %h exp %h", instruction_decode_out, mem_word(22'h0)); end
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, mem_word(22'h8));
        #1;
        checks++; if (instruction_decode_out !== 22'h12345) begin failures++; $display("FAIL st_skid: got %h exp 12345", instruction_decode_out); end
        checks++; if (pc_plus_8_out !== 22'hC) begin failures++; $display("FAIL st_skid_pc8: got %h exp c", pc_plus_8_out); end
        checks++; if (imem_addr !== 22'h8) begin failures++; $display("FAIL st_next_addr: got %h exp 8", imem_addr); end
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        #1;
        checks++; if (instruction_decode_out !== mem_word(22'h8)) begin failures++; $display("FAIL st_after: got %h exp %h", instruction_decode_out, mem_word(22'h8)); end
        checks++; if (pc_plus_8_out !== 22'h10) begin failures++; $display("FAIL st_after_pc8: got %h exp 10", pc_plus_8_out); end
    endtask

    task automatic test_flush();
        do_reset();
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, mem_word(22'h0));
        @(negedge clk);
        set_in(1'b0, 1'b1, 1'b0, '0, 1'b1, mem_word(22'h4));
        #1;
        checks++; if (instruction_decode_out !== mem_word(22'h0)) begin failures++; $display("FAIL fl_pre: got %h exp %h", instruction_decode_out, mem_word(22'h0)); end
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, mem_word(22'h4));
        #1;
        checks++; if (valid_decode_out !== 1'b0) begin failures++; $display("FAIL fl_bubble: got %b exp 0", valid_decode_out); end
        checks++; if (imem_addr !== 22'h4) begin failures++; $display("FAIL fl_refetch: got %h exp 4", imem_addr); end
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        #1;
        checks++; if (instruction_decode_out !== mem_word(22'h4)) begin failures++; $display("FAIL fl_instr: got %h exp %h", instruction_decode_out, mem_word(22'h4)); end
        checks++; if (pc_plus_8_out !== 22'hC) begin failures++; $display("FAIL fl_pc8: got %h exp c", pc_plus_8_out); end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, mem_word(W'(4 * k)));
        end
        @(negedge clk);
        set_in(1'b1, 1'b0, 1'b1, 22'h100, 1'b0, '0);
        #1;
        checks++; if (imem_addr !== 22'h20) begin failures++; $display("FAIL rd_addr: got %h exp 20", imem_addr); end
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        #1;
        checks++; if (state_dbg_o !== 2'd2) begin failures++; $display("FAIL rd_state: got %0d exp 2", state_dbg_o); end
        checks++; if (imem_addr !== 22'h20) begin failures++; $display("FAIL rd_old_addr: got %h exp 20", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rd_req: got %b exp 1", imem_req); end
        checks++; if (valid_decode_out !== 1'b0) begin failures++; $display("FAIL rd_bubble: got %b exp 0", valid_decode_out); end
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, 22'h3ABCD);
        #1;
        checks++; if (imem_addr !== 22'h20) begin failures++; $display("FAIL rd_ack_addr: got %h exp 20", imem_addr); end
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        #1;
        checks++; if (imem_addr !== 22'h100) begin failures++; $display("FAIL rd_new_addr: got %h exp 100", imem_addr); end
        checks++; if (instruction_decode_out !== 22'h0) begin failures++; $display("FAIL rd_dropped: got %h exp 0", instruction_decode_out); end
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, mem_word(22'h100));
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        #1;
        checks++; if (instruction_decode_out !== mem_word(22'h100)) begin failures++; $display("FAIL rd_tgt_instr: got %h exp %h", instruction_decode_out, mem_word(22'h100)); end
        checks++; if (pc_plus_8_out !== 22'h108) begin failures++; $display("FAIL rd_tgt_pc8: got %h exp 108", pc_plus_8_out); end
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b1, 22'h3FFFFC, 1'b1, 22'h11111);
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, mem_word(22'h3FFFFC));
        #1;
        checks++; if (imem_addr !== 22'h3FFFFC) begin failures++; $display("FAIL wr_addr: got %h exp 3ffffc", imem_addr); end
        checks++; if (valid_decode_out !== 1'b0) begin failures++; $display("FAIL wr_drop: got %b exp 0", valid_decode_out); end
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        #1;
        checks++; if (imem_addr !== 22'h0) begin failures++; $display("FAIL wr_next_addr: got %h exp 0", imem_addr); end
        checks++; if (pc_plus_8_out !== 22'h4) begin failures++; $display("FAIL wr_pc8: got %h exp 4", pc_plus_8_out); end
        checks++; if (instruction_decode_out !== mem_word(22'h3FFFFC)) begin failures++; $display("FAIL wr_instr: got %h exp %h", instruction_decode_out, mem_word(22'h3FFFFC)); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, mem_word(22'h0));
        @(negedge clk);
        set_in(1'b1, 1'b0, 1'b0, '0, 1'b1, 22'h2222);
        @(negedge clk);
        set_in(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
        #1;
        checks++; if (state_dbg_o !== 2'd1) begin failures++; $display("FAIL rm_hold: got %0d exp 1", state_dbg_o); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (valid_decode_out !== 1'b0) begin failures++; $display("FAIL rm_h_valid: got %b exp 0", valid_decode_out); end
        checks++; if (instruction_decode_out !== 22'h0) begin failures++; $display("FAIL rm_h_instr: got %h exp 0", instruction_decode_out); end
        checks++; if (pc_plus_8_out !== 22'h0) begin failures++; $display("FAIL rm_h_pc8: got %h exp 0", pc_plus_8_out); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rm_h_req: got %b exp 0", imem_req); end
        @(negedge clk);
        rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, mem_word(22'h0));
        #1;
        checks++; if (imem_addr !== 22'h0 || imem_req !== 1'b1) begin failures++; $display("FAIL rm_h_first: got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, mem_word(22'h4));
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b1, 22'h200, 1'b0, '0);
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        #1;
        checks++; if (state_dbg_o !== 2'd2 || imem_addr !== 22'h8) begin failures++; $display("FAIL rm_discard: got state=%0d addr=%h exp state=2 addr=8", state_dbg_o, imem_addr); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (state_dbg_o !== 2'd0 || imem_req !== 1'b0) begin failures++; $display("FAIL rm_d_rst: got state=%0d req=%b exp 0 0", state_dbg_o, imem_req); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (imem_addr !== 22'h0 || imem_req !== 1'b1) begin failures++; $display("FAIL rm_d_first: got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
    endtask

    task automatic test_random();
        // Model: next fetch address, optional parked word, optional abandoned request.
        logic [W-1:0] m_pc, m_hold_word, m_stale_addr, m_instr, m_pc8;
        logic         m_hold, m_stale, m_valid;
        logic         s, f, r, a, ack, exp_req;
        logic [W-1:0] t, d, exp_addr;
        do_reset();
        m_pc = '0; m_hold_word = '0; m_stale_addr = '0;
        m_instr = '0; m_pc8 = '0; m_hold = 1'b0; m_stale = 1'b0; m_valid = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 11) == 0);
            r = ($urandom_range(0, 15) == 0);
            t = ($urandom_range(0, 3) == 0) ? 22'h3FFFF8 : (W'($urandom) & ALIGN_MASK);
            a = 1'($urandom_range(0, 1));
            d = W'($urandom);
            set_in(s, f, r, t, a, d);
            #1;
            exp_req = !m_hold;
            exp_addr = m_stale ? m_stale_addr : m_pc;
            checks++; if (imem_req !== exp_req) begin failures++; $display("FAIL rnd_req cyc=%0d: got %b exp %b", cyc, imem_req, exp_req); end
            if (exp_req) begin
                checks++; if (imem_addr !== exp_addr) begin failures++; $display("FAIL rnd_addr cyc=%0d: got %h exp %h", cyc, imem_addr, exp_addr); end
            end
            checks++; if (fetch_busy !== (exp_req && !a)) begin failures++; $display("FAIL rnd_busy cyc=%0d: got %b exp %b", cyc, fetch_busy, exp_req && !a); end
            checks++; if (instruction_decode_out !== m_instr) begin failures++; $display("FAIL rnd_instr cyc=%0d: got %h exp %h", cyc, instruction_decode_out, m_instr); end
            checks++; if (pc_plus_8_out !== m_pc8) begin failures++; $display("FAIL rnd_pc8 cyc=%0d: got %h exp %h", cyc, pc_plus_8_out, m_pc8); end
            checks++; if (valid_decode_out !== m_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d: got %b exp %b", cyc, valid_decode_out, m_valid); end
            @(posedge clk);
            ack = a && exp_req;
            if (r) begin
                if (!m_hold && !ack && !m_stale) begin
                    m_stale = 1'b1;
                    m_stale_addr = m_pc;
                end else if (ack) begin
                    m_stale = 1'b0;
                end
                m_hold = 1'b0;
                m_pc = t;
                m_instr = '0; m_pc8 = '0; m_valid = 1'b0;
            end else if (m_stale) begin
                if (ack) m_stale = 1'b0;
                if (f || !s) begin m_instr = '0; m_pc8 = '0; m_valid = 1'b0; end
            end else if (m_hold) begin
                if (f) begin
                    m_hold = 1'b0;
                    m_instr = '0; m_pc8 = '0; m_valid = 1'b0;
                end else if (!s) begin
                    m_hold = 1'b0;
                    m_instr = m_hold_word; m_pc8 = m_pc + 22'd8; m_valid = 1'b1;
                    m_pc = m_pc + 22'd4;
                end
            end else if (f) begin
                m_instr = '0; m_pc8 = '0; m_valid = 1'b0;
            end else if (s) begin
                if (ack) begin m_hold = 1'b1; m_hold_word = d; end
            end else if (ack) begin
                m_instr = d; m_pc8 = m_pc + 22'd8; m_valid = 1'b1;
                m_pc = m_pc + 22'd4;
            end else begin
                m_instr = '0; m_pc8 = '0; m_valid = 1'b0;
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_hold();
        test_flush();
        test_redirect();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
